arm_shift_unit: RTL



---
 rtl/arm_shift_pkg.sv | 66 ++++++
 rtl/arm_shift_step.sv | 57 +++++
 rtl/arm_shift_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/arm_shift_pkg.sv
// arm_shift_pkg: shared types and constants for the iterative ARM operand shifter.
// Holds the shift-op encodings (the external 2-bit codes plus an internal RRX
// code), the FSM state enum, the step constants, and the decode helpers that
// turn (shift_type, amount, imm_form) into an operation and an effective count.
package arm_shift_pkg;

  // The low two bits match the external shift_type codes. RRX exists only
  // inside the unit.
  typedef enum logic [2:0] {
    SH_LSL = 3'd0,
    SH_LSR = 3'd1,
    SH_ASR = 3'd2,
    SH_ROR = 3'd3,
    SH_RRX = 3'd4
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // 33 single-bit steps are needed to push every bit of a register-form LSL/LSR out.
  localparam int MAX_COUNT = 33;
  localparam int FAST_STEP = 4;

  // Immediate ROR #0 is the RRX encoding. Every other combination keeps its own op.
  function automatic shift_op_e decode_op(input logic [1:0] st,
                                          input logic       imm,
                                          input logic [7:0] amount);
    shift_op_e op;
    op = shift_op_e'({1'b0, st});
    if (imm && (st == 2'b11) && (amount[4:0] == 5'd0)) begin
      op = SH_RRX;
    end
    return op;
  endfunction

  // Effective number of single-bit steps. Zero means "pass rm and c_in through".
  function automatic logic [5:0] eff_count(input shift_op_e  op,
                                           input logic       imm,
                                           input logic [7:0] amount);
    logic [5:0] n;
    n = 6'd0;
    if (imm) begin
      if (amount[4:0] == 5'd0) begin
        case (op)
          SH_LSL:         n = 6'd0;
          SH_LSR, SH_ASR: n = 6'd32;
          SH_RRX:         n = 6'd1;
          default:        n = 6'd0;
        endcase
      end else begin
        n = {1'b0, amount[4:0]};
      end
    end else if (amount != 8'd0) begin
      case (op)
        SH_LSL, SH_LSR: n = (amount > 8'(MAX_COUNT)) ? 6'(MAX_COUNT) : amount[5:0];
        SH_ASR:         n = (amount > 8'd32) ? 6'd32 : amount[5:0];
        default:        n = (amount[4:0] == 5'd0) ? 6'd32 : {1'b0, amount[4:0]};
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/arm_shift_step.sv
// arm_shift_step: combinational shift of 1..4 bit positions. It is built as k
// chained single-bit steps, so the carry is always the last bit shifted out.
// RRX is only ever requested with k = 1.
module arm_shift_step
  import arm_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic             c,
  input  shift_op_e        op,
  input  logic [2:0]       k,
  output logic [WIDTH-1:0] r_next,
  output logic             c_next
);

  // Apply the first k single-bit steps in sequence.
  always_comb begin
    logic [WIDTH-1:0] rr;
    logic             cc;
    rr = r;
    cc = c;
    for (int i = 0; i < FAST_STEP; i++) begin
      if (i < int'(k)) begin
        case (op)
          SH_LSL: begin
            cc = rr[WIDTH-1];
            rr = {rr[WIDTH-2:0], 1'b0};
          end
          SH_LSR: begin
            cc = rr[0];
            rr = {1'b0, rr[WIDTH-1:1]};
          end
          SH_ASR: begin
            cc = rr[0];
            rr = {rr[WIDTH-1], rr[WIDTH-1:1]};
          end
          SH_ROR: begin
            cc = rr[0];
            rr = {rr[0], rr[WIDTH-1:1]};
          end
          SH_RRX: begin
            rr = {cc, rr[WIDTH-1:1]};
            cc = r[0];
          end
          default: begin
            rr = rr;
            cc = cc;
          end
        endcase
      end
    end
    r_next = rr;
    c_next = cc;
  end

endmodule

// File: rtl/arm_shift_unit.sv
// arm_shift_unit: iterative ARM barrel-shifter stage that feeds the ALU B operand.
// It captures rm, c_in, the decoded op and the effective count on an accepted
// start, shifts over several cycles, and then pulses done with result/c_out valid.
// Build option ARM_SHIFT_FAST_EN: when defined, each SHIFT edge consumes up to
// FAST_STEP bits of the count instead of one. Results are unchanged.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_SHIFT | stepping the working register, busy high
// ST_DONE  | done pulse; result/c_out valid; a new start is accepted here
module arm_shift_unit
  import arm_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] rm,
  input  logic [7:0]       amount,
  input  logic [1:0]       shift_type,
  input  logic             imm_form,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out
);

  localparam logic [5:0] FAST_K = 6'(FAST_STEP);

  state_e           state;
  shift_op_e        op_q;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] work_r;
  logic             work_c;

  shift_op_e        ld_op;
  logic [5:0]       ld_n;
  logic [2:0]       step_k;
  logic [WIDTH-1:0] step_r;
  logic             step_c;

  assign ld_op = decode_op(shift_type, imm_form, amount);
  assign ld_n  = eff_count(ld_op, imm_form, amount);

`ifdef ARM_SHIFT_FAST_EN
  assign step_k = (cnt >= FAST_K) ? FAST_K[2:0] : cnt[2:0];
`else
  assign step_k = 3'd1;
`endif

  arm_shift_step #(.WIDTH(WIDTH)) u_step (
    .r      (work_r),
    .c      (work_c),
    .op     (op_q),
    .k      (step_k),
    .r_next (step_r),
    .c_next (step_c)
  );

  // Control FSM with registered busy/done. The working registers are kept
  // separate from result/c_out so that the outputs hold the previous result
  // until the first shift edge of the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= SH_LSL;
      cnt    <= 6'd0;
      work_r <= '0;
      work_c <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
          if (start) begin
            op_q   <= ld_op;
            cnt    <= ld_n;
            work_r <= rm;
            work_c <= c_in;
            if (ld_n == 6'd0) begin
              result <= rm;
              c_out  <= c_in;
              done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              busy  <= 1'b1;
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          work_r <= step_r;
          work_c <= step_c;
          result <= step_r;
          c_out  <= step_c;
          cnt    <= cnt - {3'b000, step_k};
          if (cnt == {3'b000, step_k}) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
